// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard controller for the 5-stage MIPS pipeline. It produces
//                the stall/flush controls for Fetch, F/D and D/E and selects
//                the E-stage forwarding sources. It covers load-use stalls,
//                E-stage redirects and the HI/LO interlock against the
//                multi-cycle mult/div unit.
//  Options     : define HAZARD_PERF_CNT_EN to add the stall_cycles and
//                flush_count performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int WIDTH_5   = 5,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH_5-1:0] Rs_D,
  input  logic [WIDTH_5-1:0] Rt_D,
  input  logic               uses_rt_D,
  input  logic               md_use_D,
  input  logic [WIDTH_5-1:0] Rs_E,
  input  logic [WIDTH_5-1:0] Rt_E,
  input  logic [WIDTH_5-1:0] WriteReg_E,
  input  logic               RegWrite_E,
  input  logic               MemtoReg_E,
  input  logic [WIDTH_5-1:0] WriteReg_M,
  input  logic               RegWrite_M,
  input  logic [WIDTH_5-1:0] WriteReg_W,
  input  logic               RegWrite_W,
  input  logic               redirect_E,
  input  logic               md_start_E,
  output logic               StallF,
  output logic               StallD,
  output logic               FlushD,
  output logic               EN_DE,
  output logic               CLR_DE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             lw_stall;
  logic             md_stall;

  // Mult/div tracker: counter runs in BUSY, busy flag trails the state by one
  // edge so it stays high for exactly MD_CYCLES cycles after the start pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = (state_q == BUSY) || md_start_E;
    if (md_start_E) begin
      state_d = BUSY;
      cnt_d   = CNT_LOAD;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CNT_LAST;
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
      end
    end
  end

  // State, counter and busy flag registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign md_busy = busy_q;

  // Forwarding select: the younger M-stage result beats W; $0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWrite_M && (WriteReg_M != '0) && (WriteReg_M == Rs_E)) begin
      ForwardAE = 2'b10;
    end else if (RegWrite_W && (WriteReg_W != '0) && (WriteReg_W == Rs_E)) begin
      ForwardAE = 2'b01;
    end
    if (RegWrite_M && (WriteReg_M != '0) && (WriteReg_M == Rt_E)) begin
      ForwardBE = 2'b10;
    end else if (RegWrite_W && (WriteReg_W != '0) && (WriteReg_W == Rt_E)) begin
      ForwardBE = 2'b01;
    end
  end

  assign lw_stall = MemtoReg_E && RegWrite_E && (WriteReg_E != '0) &&
                    ((WriteReg_E == Rs_D) || (uses_rt_D && (WriteReg_E == Rt_D)));
  assign md_stall = md_use_D && (busy_q || md_start_E);

  // Pipeline control: a redirect kills the wrong path, otherwise a stall
  // holds F/D and injects a bubble (EN_DE=0, CLR_DE=1) into E.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    EN_DE  = 1'b1;
    CLR_DE = 1'b0;
    if (redirect_E) begin
      FlushD = 1'b1;
      EN_DE  = 1'b0;
      CLR_DE = 1'b1;
    end else if (lw_stall || md_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      EN_DE  = 1'b0;
      CLR_DE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Performance counters: stalled cycles and redirect cycles, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (StallF) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (redirect_E) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int MD = 4;

  typedef struct packed {
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       urt;
    logic       mdu;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] wr_e;
    logic       rw_e;
    logic       m2r;
    logic [4:0] wr_m;
    logic       rw_m;
    logic [4:0] wr_w;
    logic       rw_w;
    logic       redir;
    logic       start;
    logic [4:0] ctl;   // {StallF,StallD,FlushD,EN_DE,CLR_DE}
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic uses_rt_D, md_use_D, RegWrite_E, MemtoReg_E, RegWrite_M, RegWrite_W;
  logic redirect_E, md_start_E;
  logic StallF, StallD, FlushD, EN_DE, CLR_DE, md_busy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_left = 0;
  int m_stalls  = 0;
  int m_flushes = 0;
  vec_t tab[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WIDTH_5(5), .MD_CYCLES(MD), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .uses_rt_D(uses_rt_D), .md_use_D(md_use_D),
    .Rs_E(Rs_E), .Rt_E(Rt_E), .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E),
    .MemtoReg_E(MemtoReg_E), .WriteReg_M(WriteReg_M), .RegWrite_M(RegWrite_M),
    .WriteReg_W(WriteReg_W), .RegWrite_W(RegWrite_W), .redirect_E(redirect_E),
    .md_start_E(md_start_E), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .EN_DE(EN_DE), .CLR_DE(CLR_DE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .md_busy(md_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // Field order: rs_d rt_d urt mdu rs_e rt_e wr_e rw_e m2r wr_m rw_m wr_w rw_w redir start | ctl fa fb
  function automatic vec_t mk(int rs_d, int rt_d, bit urt, bit mdu, int rs_e, int rt_e,
                              int wr_e, bit rw_e, bit m2r, int wr_m, bit rw_m, int wr_w,
                              bit rw_w, bit redir, bit start, logic [4:0] ctl,
                              logic [1:0] fa, logic [1:0] fb);
    vec_t v;
    v.rs_d = 5'(rs_d); v.rt_d = 5'(rt_d); v.urt = urt; v.mdu = mdu;
    v.rs_e = 5'(rs_e); v.rt_e = 5'(rt_e); v.wr_e = 5'(wr_e); v.rw_e = rw_e; v.m2r = m2r;
    v.wr_m = 5'(wr_m); v.rw_m = rw_m; v.wr_w = 5'(wr_w); v.rw_w = rw_w;
    v.redir = redir; v.start = start; v.ctl = ctl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  // Reference: control word straight from the hazard rules.
  function automatic logic [8:0] ref_out(vec_t v, bit busy);
    bit lw, md;
    logic [1:0] fa, fb;
    logic [4:0] ctl;
    lw = v.m2r && v.rw_e && (v.wr_e != 0) &&
         ((v.wr_e == v.rs_d) || (v.urt && (v.wr_e == v.rt_d)));
    md = v.mdu && (busy || v.start);
    fa = (v.rw_m && v.wr_m != 0 && v.wr_m == v.rs_e) ? 2'b10 :
         (v.rw_w && v.wr_w != 0 && v.wr_w == v.rs_e) ? 2'b01 : 2'b00;
    fb = (v.rw_m && v.wr_m != 0 && v.wr_m == v.rt_e) ? 2'b10 :
         (v.rw_w && v.wr_w != 0 && v.wr_w == v.rt_e) ? 2'b01 : 2'b00;
    ctl = v.redir ? 5'b00101 : (lw || md) ? 5'b11001 : 5'b00010;
    return {ctl, fa, fb};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Rs_D = v.rs_d; Rt_D = v.rt_d; uses_rt_D = v.urt; md_use_D = v.mdu;
    Rs_E = v.rs_e; Rt_E = v.rt_e; WriteReg_E = v.wr_e; RegWrite_E = v.rw_e;
    MemtoReg_E = v.m2r; WriteReg_M = v.wr_m; RegWrite_M = v.rw_m;
    WriteReg_W = v.wr_w; RegWrite_W = v.rw_w; redirect_E = v.redir; md_start_E = v.start;
  endtask

  // Advance the model across one rising edge.
  task automatic model_step(input vec_t v);
    logic [8:0] r;
    r = ref_out(v, busy_left > 0);
    if (r[8]) m_stalls++;
    if (v.redir) m_flushes++;
    if (v.start) busy_left = MD;
    else if (busy_left > 0) busy_left--;
  endtask

  // One cycle: drive after the edge, compare at the falling edge, then clock.
  task automatic apply(input vec_t v, input bit use_ref, input string nm);
    logic [8:0] e;
    drive(v);
    @(negedge clk);
    e = use_ref ? ref_out(v, busy_left > 0) : {v.ctl, v.fa, v.fb};
    chk({nm, ".ctl"}, {27'd0, StallF, StallD, FlushD, EN_DE, CLR_DE}, {27'd0, e[8:4]});
    chk({nm, ".fa"}, {30'd0, ForwardAE}, {30'd0, e[3:2]});
    chk({nm, ".fb"}, {30'd0, ForwardBE}, {30'd0, e[1:0]});
    chk({nm, ".busy"}, {31'd0, md_busy}, {31'd0, busy_left > 0});
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    idle = '0;

    // Directed table.
    tab.push_back(mk(1,2,1,0, 4,5, 6,1,0, 7,0, 8,0, 0,0, 5'b00010,2'b00,2'b00)); // quiet
    tab.push_back(mk(2,9,1,0, 0,0, 2,1,1, 0,0, 0,0, 0,0, 5'b11001,2'b00,2'b00)); // lw $2 -> Rs_D
    // lw sequence: bubble cycle, then consumer in E with producer in W
    tab.push_back(mk(2,9,1,0, 0,0, 0,0,0, 2,1, 0,0, 0,0, 5'b00010,2'b00,2'b00));
    tab.push_back(mk(0,0,0,0, 2,9, 0,0,0, 0,0, 2,1, 0,0, 5'b00010,2'b01,2'b00));
    tab.push_back(mk(5,2,1,0, 0,0, 2,1,1, 0,0, 0,0, 0,0, 5'b11001,2'b00,2'b00)); // Rt match
    tab.push_back(mk(5,2,0,0, 0,0, 2,1,1, 0,0, 0,0, 0,0, 5'b00010,2'b00,2'b00)); // Rt unused
    tab.push_back(mk(0,0,1,0, 0,0, 0,1,1, 0,0, 0,0, 0,0, 5'b00010,2'b00,2'b00)); // lw $0
    tab.push_back(mk(2,2,1,0, 0,0, 2,0,1, 0,0, 0,0, 0,0, 5'b00010,2'b00,2'b00)); // no RegWrite
    tab.push_back(mk(0,0,0,0, 3,0, 0,0,0, 3,1, 3,1, 0,0, 5'b00010,2'b10,2'b00)); // M beats W
    tab.push_back(mk(0,0,0,0, 3,0, 0,0,0, 4,1, 3,1, 0,0, 5'b00010,2'b01,2'b00)); // W only
    tab.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,1, 0,1, 0,0, 5'b00010,2'b00,2'b00)); // $0 dest
    tab.push_back(mk(0,0,0,0, 8,7, 0,0,0, 7,1, 8,1, 0,0, 5'b00010,2'b01,2'b10)); // B from M
    tab.push_back(mk(0,0,0,0, 3,3, 0,0,0, 3,0, 3,1, 0,0, 5'b00010,2'b01,2'b01)); // M no write
    tab.push_back(mk(2,0,0,0, 0,0, 2,1,1, 0,0, 0,0, 1,0, 5'b00101,2'b00,2'b00)); // redirect+lw
    tab.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1,0, 5'b00101,2'b00,2'b00)); // redirect
    tab.push_back(mk(0,0,0,1, 0,0, 0,0,0, 0,0, 0,0, 0,0, 5'b00010,2'b00,2'b00)); // md idle
    tab.push_back(mk(0,0,0,1, 0,0, 0,0,0, 0,0, 0,0, 0,1, 5'b11001,2'b00,2'b00)); // md start

    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.ctl", {27'd0, StallF, StallD, FlushD, EN_DE, CLR_DE}, 32'h02);
    chk("reset.fwd", {28'd0, ForwardAE, ForwardBE}, 32'h0);
    chk("reset.busy", {31'd0, md_busy}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tab[i]) apply(tab[i], 1'b0, $sformatf("tab%0d", i));
    for (int i = 0; i < MD + 2; i++) apply(idle, 1'b1, "drain");

    // mflo held behind a mult started in the same cycle.
    for (int k = 0; k <= MD + 1; k++) begin
      v = idle;
      v.mdu = 1'b1;
      v.start = (k == 0);
      drive(v);
      @(negedge clk);
      chk($sformatf("mdseq%0d.stall", k), {31'd0, StallF}, {31'd0, k <= MD});
      chk($sformatf("mdseq%0d.busy", k), {31'd0, md_busy}, {31'd0, (k >= 1) && (k <= MD)});
      @(posedge clk);
      model_step(v);
      #1;
    end
    for (int i = 0; i < MD + 2; i++) apply(idle, 1'b1, "drain2");

    // Reset while busy with two cycles left on the counter.
    v = idle;
    v.start = 1'b1;
    apply(v, 1'b1, "rst.start");
    apply(idle, 1'b1, "rst.c1");
    drive(idle);
    #2;
    chk("rst.busy_before", {31'd0, md_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst.busy_async", {31'd0, md_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_left = 0;
    m_stalls = 0;
    m_flushes = 0;
    @(posedge clk);
    #1;
    v = idle;
    v.mdu = 1'b1;
    v.ctl = 5'b00010;
    apply(v, 1'b0, "rst.mflo");

    // Three load-use stalls and two redirects.
    for (int i = 0; i < 3; i++) apply(tab[1], 1'b0, "perf.lw");
    for (int i = 0; i < 2; i++) apply(tab[14], 1'b0, "perf.redir");
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.stall_cycles", stall_cycles, 32'd3);
    chk("perf.flush_count", flush_count, 32'd2);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      v = '0;
      v.rs_d = 5'($urandom_range(0, 3)); v.rt_d = 5'($urandom_range(0, 3));
      v.urt = 1'($urandom); v.mdu = ($urandom_range(0, 3) == 0);
      v.rs_e = 5'($urandom_range(0, 3)); v.rt_e = 5'($urandom_range(0, 3));
      v.wr_e = 5'($urandom_range(0, 3)); v.rw_e = 1'($urandom); v.m2r = 1'($urandom);
      v.wr_m = 5'($urandom_range(0, 3)); v.rw_m = 1'($urandom);
      v.wr_w = 5'($urandom_range(0, 3)); v.rw_w = 1'($urandom);
      v.redir = ($urandom_range(0, 7) == 0);
      v.start = ($urandom_range(0, 15) == 0);
      apply(v, 1'b1, $sformatf("rnd%0d", n));
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("rnd.stall_cycles", stall_cycles, 32'(m_stalls));
    chk("rnd.flush_count", flush_count, 32'(m_flushes));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
